uart_cmd_parser: RTL and testbench
==================================

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 The block SHALL use one clock, and its reset SHALL be asynchronous and active-high: ports "clock" and "reset".
REQ-002 Parameters (name, default, meaning) SHALL be:
- SYNC_BYTE, 8'hA5, frame start marker.
- ACK_BYTE, 8'h06, response to a good frame.
- NAK_BYTE, 8'h15, response to a bad checksum.
- TIMEOUT_CYCLES, 56250, maximum clock cycles allowed between bytes inside a frame.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- clock, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- rx_empty, in, 1, RX FIFO empty flag.
- rx_data, in, 8, RX FIFO head byte; valid while rx_empty=0.
- rx_remove, out, 1, pops the RX FIFO head on the clock edge.
- tx_full, in, 1, TX FIFO full flag.
- tx_insert, out, 1, pushes tx_data into the TX FIFO on the clock edge.
- tx_data, out, 8, response byte.
- reg_write, out, 1, one-cycle strobe for a register write.
- reg_addr, out, 8, register address; held until the next accepted frame.
- reg_data, out, 16, register data; held until the next accepted frame.
- frame_error, out, 1, one-cycle strobe on a checksum failure or a timeout.

Function
REQ-004 The frame format SHALL be five bytes in this order: SYNC_BYTE, ADDR, DATA_LO, DATA_HI, CHK.
REQ-005 CHK SHALL be ADDR ^ DATA_LO ^ DATA_HI (bitwise XOR, 8 bits).
REQ-006 FSM states SHALL be HUNT, ADDR, DLO, DHI, CHK, RESPOND.
REQ-007 In states HUNT, ADDR, DLO, DHI and CHK, rx_remove SHALL equal ~rx_empty combinationally, and rx_data SHALL be captured on the same edge.
REQ-008 In RESPOND, rx_remove SHALL be 0; RX bytes remain queued in the FIFO.
REQ-009 In HUNT, a byte equal to SYNC_BYTE SHALL cause a transition to ADDR; any other byte SHALL be discarded silently, with no frame_error.
REQ-010 Within a frame, each consumed byte SHALL advance the state: ADDR -> DLO -> DHI -> CHK; the byte values are stored in internal registers.
REQ-011 A SYNC_BYTE value appearing inside a frame SHALL be treated as ordinary data; the parser SHALL NOT resynchronise on it.
REQ-012 When the CHK byte is consumed and matches, the parser SHALL, on the next cycle:
- assert reg_write for exactly 1 cycle;
- update reg_addr and reg_data = {DATA_HI, DATA_LO} on the same edge that raises reg_write;
- load ACK_BYTE as the pending response;
- enter RESPOND.
REQ-013 When the CHK byte mismatches, the parser SHALL:
- assert frame_error for 1 cycle;
- leave reg_write, reg_addr and reg_data unchanged;
- load NAK_BYTE as the pending response;
- enter RESPOND.
REQ-014 In RESPOND, tx_insert SHALL equal ~tx_full, tx_data SHALL equal the pending byte, and the parser SHALL return to HUNT on the edge where tx_insert=1.
REQ-015 While tx_full=1, the parser SHALL remain in RESPOND indefinitely, with no timeout.
REQ-016 The timeout counter SHALL be $clog2(TIMEOUT_CYCLES+1) bits wide, and SHALL count only in ADDR, DLO, DHI and CHK.
REQ-017 The timeout counter SHALL clear on every consumed byte and on every entry to ADDR.
REQ-018 When the counter reaches TIMEOUT_CYCLES with no byte present, the parser SHALL:
- assert frame_error for 1 cycle;
- discard the partial frame and send no response;
- return to HUNT.
REQ-019 When a byte arrives in the same cycle the counter reaches TIMEOUT_CYCLES, the byte SHALL win and no timeout SHALL occur.
REQ-020 tx_insert SHALL be 0 in every state other than RESPOND.
REQ-021 reg_write and frame_error SHALL never be asserted in the same cycle.

Reset
REQ-022 While reset is asserted:
- the state SHALL be HUNT and the timeout counter SHALL be 0;
- reg_write, frame_error and tx_insert SHALL be 0;
- rx_remove SHALL be forced to 0;
- reg_addr, reg_data and tx_data SHALL be 0.
REQ-023 A reset asserted mid-frame or in RESPOND SHALL abandon the frame, with no strobe and no response.
REQ-024 After reset is released, the parser SHALL be ready to consume from the first rising edge.

Structure
REQ-025 Package uart_cmd_pkg SHALL hold the FSM state enum, the frame-length constant (5) and the default SYNC, ACK and NAK byte constants.
REQ-026 The timeout counter SHALL be inline and no sub-module SHALL be required; the block connects directly to UartFIFO instances on its RX and TX sides.

Verification
REQ-027 Good frame A5 10 34 12 36 -> one reg_write with reg_addr=8'h10 and reg_data=16'h1234, tx byte 8'h06, no frame_error.
REQ-028 Bad checksum A5 10 34 12 37 -> frame_error pulse, tx byte 8'h15, reg_write never asserted, reg_addr/reg_data unchanged.
REQ-029 Noise 00 FF A5 01 00 00 01 -> 00 and FF discarded silently, one reg_write with addr=8'h01 and data=16'h0000, ACK sent.
REQ-030 A5 10 then stall for TIMEOUT_CYCLES (set to 100 for the test) -> frame_error pulse, no tx_insert, back in HUNT; a following good frame is accepted.
REQ-031 tx_full held high for 50 cycles after the CHK byte, with a second frame queued -> rx_remove stays 0 and the state stays RESPOND; after release, ACK is inserted and then the second frame parses.
REQ-032 Reset asserted after A5 10 34 -> all outputs 0 immediately (asynchronous); after release, the remaining bytes 12 36 are discarded in HUNT with no strobes.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-frame parser.
package uart_cmd_pkg;

   typedef enum logic [2:0] {
      ST_HUNT    = 3'd0,
      ST_ADDR    = 3'd1,
      ST_DLO     = 3'd2,
      ST_DHI     = 3'd3,
      ST_CHK     = 3'd4,
      ST_RESPOND = 3'd5
   } state_e;

   localparam int unsigned FRAME_LEN     = 5;
   localparam logic [7:0]  DEF_SYNC_BYTE = 8'hA5;
   localparam logic [7:0]  DEF_ACK_BYTE  = 8'h06;
   localparam logic [7:0]  DEF_NAK_BYTE  = 8'h15;

   function automatic logic [7:0] frame_chk(input logic [7:0] addr,
                                            input logic [7:0] dlo,
                                            input logic [7:0] dhi);
      return addr ^ dlo ^ dhi;
   endfunction

endpackage

// File: rtl/uart_cmd_parser.sv
// Parses SYNC/ADDR/DLO/DHI/CHK frames from an RX FIFO into register writes
// and answers each completed frame with ACK or NAK through a TX FIFO.
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter logic [7:0]  SYNC_BYTE      = DEF_SYNC_BYTE,
   parameter logic [7:0]  ACK_BYTE       = DEF_ACK_BYTE,
   parameter logic [7:0]  NAK_BYTE       = DEF_NAK_BYTE,
   parameter int unsigned TIMEOUT_CYCLES = 56250
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        rx_empty,
   input  logic [7:0]  rx_data,
   output logic        rx_remove,
   input  logic        tx_full,
   output logic        tx_insert,
   output logic [7:0]  tx_data,
   output logic        reg_write,
   output logic [7:0]  reg_addr,
   output logic [15:0] reg_data,
   output logic        frame_error
);

   localparam int unsigned     CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             reg_write_q, reg_write_d;
   logic             frame_error_q, frame_error_d;
   logic [7:0]       reg_addr_q, reg_addr_d;
   logic [15:0]      reg_data_q, reg_data_d;
   logic [7:0]       pend_q, pend_d;
   logic [7:0]       addr_q, dlo_q, dhi_q;
   logic             in_frame;

   assign in_frame = (state_q == ST_ADDR) || (state_q == ST_DLO) ||
                     (state_q == ST_DHI)  || (state_q == ST_CHK);

   // Reset gates the strobes combinationally so they drop the instant reset rises.
   assign rx_remove   = ~reset & ~rx_empty & (state_q != ST_RESPOND);
   assign tx_insert   = ~reset & ~tx_full & (state_q == ST_RESPOND);
   assign tx_data     = pend_q;
   assign reg_write   = reg_write_q;
   assign frame_error = frame_error_q;
   assign reg_addr    = reg_addr_q;
   assign reg_data    = reg_data_q;

   always_comb begin
      state_d       = state_q;
      tmo_cnt_d     = tmo_cnt_q;
      reg_write_d   = 1'b0;
      frame_error_d = 1'b0;
      reg_addr_d    = reg_addr_q;
      reg_data_d    = reg_data_q;
      pend_d        = pend_q;
      case (state_q)
         ST_HUNT: begin
            tmo_cnt_d = '0;
            if (rx_remove && (rx_data == SYNC_BYTE)) state_d = ST_ADDR;
         end
         ST_ADDR, ST_DLO, ST_DHI, ST_CHK: begin
            // A byte present on the deadline cycle still counts as on time.
            if (rx_remove) begin
               tmo_cnt_d = '0;
               case (state_q)
                  ST_ADDR: state_d = ST_DLO;
                  ST_DLO:  state_d = ST_DHI;
                  ST_DHI:  state_d = ST_CHK;
                  default: begin
                     state_d = ST_RESPOND;
                     if (frame_chk(addr_q, dlo_q, dhi_q) == rx_data) begin
                        reg_write_d = 1'b1;
                        reg_addr_d  = addr_q;
                        reg_data_d  = {dhi_q, dlo_q};
                        pend_d      = ACK_BYTE;
                     end else begin
                        frame_error_d = 1'b1;
                        pend_d        = NAK_BYTE;
                     end
                  end
               endcase
            end else if (tmo_cnt_q == CNT_MAX) begin
               frame_error_d = 1'b1;
               tmo_cnt_d     = '0;
               state_d       = ST_HUNT;
            end else begin
               tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
            end
         end
         ST_RESPOND: begin
            tmo_cnt_d = '0;
            if (tx_insert) state_d = ST_HUNT;
         end
         default: begin
            tmo_cnt_d = '0;
            state_d   = ST_HUNT;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= ST_HUNT;
         tmo_cnt_q     <= '0;
         reg_write_q   <= 1'b0;
         frame_error_q <= 1'b0;
         reg_addr_q    <= '0;
         reg_data_q    <= '0;
         pend_q        <= '0;
      end else begin
         state_q       <= state_d;
         tmo_cnt_q     <= tmo_cnt_d;
         reg_write_q   <= reg_write_d;
         frame_error_q <= frame_error_d;
         reg_addr_q    <= reg_addr_d;
         reg_data_q    <= reg_data_d;
         pend_q        <= pend_d;
      end
   end

   // Frame payload bytes; only ever read after being written within the same frame.
   always_ff @(posedge clock) begin
      if (rx_remove && (state_q == ST_ADDR)) addr_q <= rx_data;
      if (rx_remove && (state_q == ST_DLO))  dlo_q  <= rx_data;
      if (rx_remove && (state_q == ST_DHI))  dhi_q  <= rx_data;
   end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with behavioural RX/TX FIFO models.
module tb_uart_cmd_parser;
   import uart_cmd_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        rx_empty;
   logic [7:0]  rx_data;
   logic        rx_remove;
   logic        tx_full;
   logic        tx_insert;
   logic [7:0]  tx_data;
   logic        reg_write;
   logic [7:0]  reg_addr;
   logic [15:0] reg_data;
   logic        frame_error;

   uart_cmd_parser #(
      .SYNC_BYTE     (8'hA5),
      .ACK_BYTE      (8'h06),
      .NAK_BYTE      (8'h15),
      .TIMEOUT_CYCLES(100)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .rx_empty   (rx_empty),
      .rx_data    (rx_data),
      .rx_remove  (rx_remove),
      .tx_full    (tx_full),
      .tx_insert  (tx_insert),
      .tx_data    (tx_data),
      .reg_write  (reg_write),
      .reg_addr   (reg_addr),
      .reg_data   (reg_data),
      .frame_error(frame_error)
   );

   always #5 clock = ~clock;

   logic [7:0]  rxq[$];
   logic [7:0]  txq[$];
   int          n_pass = 0;
   int          n_total = 0;
   int          wr_cnt, fe_cnt, both_cnt;
   logic [7:0]  last_addr;
   logic [15:0] last_data;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic refresh();
      rx_empty = (rxq.size() == 0);
      rx_data  = rx_empty ? 8'h00 : rxq[0];
   endtask

   task automatic push(input logic [7:0] b);
      rxq.push_back(b);
      refresh();
   endtask

   task automatic clear_log();
      wr_cnt = 0; fe_cnt = 0; both_cnt = 0;
      last_addr = 8'h00; last_data = 16'h0000;
      txq.delete();
   endtask

   // Sample before the edge, then apply FIFO side effects just after it.
   task automatic tick();
      logic rem, ins;
      @(negedge clock);
      rem = rx_remove;
      ins = tx_insert;
      if (ins) txq.push_back(tx_data);
      if (reg_write) begin
         wr_cnt++; last_addr = reg_addr; last_data = reg_data;
      end
      if (frame_error) fe_cnt++;
      if (reg_write && frame_error) both_cnt++;
      @(posedge clock);
      #1;
      if (rem && rxq.size() != 0) void'(rxq.pop_front());
      refresh();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int guard;
      reset = 1'b1; tx_full = 1'b0;
      clear_log();
      refresh();
      push(8'hA5);
      #3;
      // Reset state
      check("rst_rx_remove", rx_remove, 0);
      check("rst_tx_insert", tx_insert, 0);
      check("rst_reg_write", reg_write, 0);
      check("rst_frame_error", frame_error, 0);
      check("rst_reg_addr", reg_addr, 8'h00);
      check("rst_reg_data", reg_data, 16'h0000);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_state", dut.state_q, ST_HUNT);
      ticks(2);
      reset = 1'b0;
      #1;
      check("first_edge_ready", rx_remove, 1);

      // Good frame A5 10 34 12 36
      push(8'h10); push(8'h34); push(8'h12); push(8'h36);
      ticks(12);
      check("good_wr_cnt", wr_cnt, 1);
      check("good_addr", last_addr, 8'h10);
      check("good_data", last_data, 16'h1234);
      check("good_tx_cnt", txq.size(), 1);
      check("good_tx_byte", (txq.size() > 0) ? txq[0] : 8'hXX, 8'h06);
      check("good_fe_cnt", fe_cnt, 0);
      check("good_state", dut.state_q, ST_HUNT);

      // Bad checksum A5 10 34 12 37
      clear_log();
      push(8'hA5); push(8'h10); push(8'h34); push(8'h12); push(8'h37);
      ticks(12);
      check("bad_fe_cnt", fe_cnt, 1);
      check("bad_wr_cnt", wr_cnt, 0);
      check("bad_tx_cnt", txq.size(), 1);
      check("bad_tx_byte", (txq.size() > 0) ? txq[0] : 8'hXX, 8'h15);
      check("bad_addr_held", reg_addr, 8'h10);
      check("bad_data_held", reg_data, 16'h1234);

      // Noise then frame: 00 FF A5 01 00 00 01
      clear_log();
      push(8'h00); push(8'hFF); push(8'hA5); push(8'h01);
      push(8'h00); push(8'h00); push(8'h01);
      ticks(14);
      check("noise_fe_cnt", fe_cnt, 0);
      check("noise_wr_cnt", wr_cnt, 1);
      check("noise_addr", last_addr, 8'h01);
      check("noise_data", last_data, 16'h0000);
      check("noise_tx_cnt", txq.size(), 1);
      check("noise_tx_byte", (txq.size() > 0) ? txq[0] : 8'hXX, 8'h06);

      // Timeout after A5 10, then a good frame A5 20 CD AB 46
      clear_log();
      push(8'hA5); push(8'h10);
      ticks(90);
      check("tmo_early_fe", fe_cnt, 0);
      check("tmo_early_state", dut.state_q, ST_DLO);
      ticks(20);
      check("tmo_fe_cnt", fe_cnt, 1);
      check("tmo_tx_cnt", txq.size(), 0);
      check("tmo_state", dut.state_q, ST_HUNT);
      push(8'hA5); push(8'h20); push(8'hCD); push(8'hAB); push(8'h46);
      ticks(12);
      check("post_tmo_wr_cnt", wr_cnt, 1);
      check("post_tmo_addr", last_addr, 8'h20);
      check("post_tmo_data", last_data, 16'hABCD);
      check("post_tmo_tx", (txq.size() > 0) ? txq[0] : 8'hXX, 8'h06);

      // Byte arriving on the deadline cycle wins over the timeout
      clear_log();
      push(8'hA5);
      tick();
      guard = 0;
      while (dut.tmo_cnt_q != 7'd100 && guard < 200) begin
         tick(); guard++;
      end
      check("deadline_reached", dut.tmo_cnt_q, 7'd100);
      push(8'h77);
      ticks(2);
      check("deadline_no_fe", fe_cnt, 0);
      check("deadline_state", dut.state_q, ST_DLO);
      push(8'h00); push(8'h00); push(8'h77);
      ticks(8);
      check("deadline_wr_cnt", wr_cnt, 1);
      check("deadline_addr", last_addr, 8'h77);

      // TX backpressure with a second frame queued
      clear_log();
      tx_full = 1'b1;
      push(8'hA5); push(8'h10); push(8'h34); push(8'h12); push(8'h36);
      push(8'hA5); push(8'h30); push(8'h02); push(8'h01); push(8'h33);
      ticks(55);
      check("bp_state", dut.state_q, ST_RESPOND);
      check("bp_rx_remove", rx_remove, 0);
      check("bp_queued", rxq.size(), 5);
      check("bp_tx_cnt", txq.size(), 0);
      check("bp_fe_cnt", fe_cnt, 0);
      tx_full = 1'b0;
      ticks(15);
      check("bp_tx_total", txq.size(), 2);
      check("bp_tx_first", (txq.size() > 0) ? txq[0] : 8'hXX, 8'h06);
      check("bp_wr_cnt", wr_cnt, 2);
      check("bp_addr2", last_addr, 8'h30);
      check("bp_data2", last_data, 16'h0102);

      // Reset mid-frame after A5 10 34
      clear_log();
      push(8'hA5); push(8'h10); push(8'h34); push(8'h12); push(8'h36);
      ticks(3);
      check("mid_state_pre", dut.state_q, ST_DHI);
      reset = 1'b1;
      #1;
      check("mid_rx_remove", rx_remove, 0);
      check("mid_reg_addr", reg_addr, 8'h00);
      check("mid_reg_data", reg_data, 16'h0000);
      check("mid_tx_data", tx_data, 8'h00);
      check("mid_tx_insert", tx_insert, 0);
      check("mid_state", dut.state_q, ST_HUNT);
      ticks(2);
      reset = 1'b0;
      ticks(6);
      check("mid_rx_drained", rxq.size(), 0);
      check("mid_wr_cnt", wr_cnt, 0);
      check("mid_fe_cnt", fe_cnt, 0);
      check("mid_tx_cnt", txq.size(), 0);
      check("mid_state_post", dut.state_q, ST_HUNT);
      check("never_both", both_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
